// File: rtl/runahead_speculation_validator_if.sv
// Clear-queue entry, retire and rewind handshake bundle for the runahead validator.
// Slave modport is the validator; master modport is the surrounding queue/FIFO logic.
interface runahead_speculation_validator_if #(
    parameter int COUNTERBITWIDTH = 6
);
    logic                       ClearEntryValid;
    logic                       ClearEntryMispredicted;
    logic [COUNTERBITWIDTH-1:0] ClearEntryDepth;
    logic                       ClearEntryACK;
    logic                       SpeculativeRetire;
    logic                       RewindValid;
    logic [COUNTERBITWIDTH-1:0] RewindDepth;
    logic                       RewindACK;
    logic                       ValidatedPulse;
    logic                       ValidatorBusy;
    logic                       ProtocolError;

    modport slave (
        input  ClearEntryValid, ClearEntryMispredicted, ClearEntryDepth,
        input  SpeculativeRetire, RewindACK,
        output ClearEntryACK, RewindValid, RewindDepth,
        output ValidatedPulse, ValidatorBusy, ProtocolError
    );

    modport master (
        output ClearEntryValid, ClearEntryMispredicted, ClearEntryDepth,
        output SpeculativeRetire, RewindACK,
        input  ClearEntryACK, RewindValid, RewindDepth,
        input  ValidatedPulse, ValidatorBusy, ProtocolError
    );
endinterface

// File: rtl/runahead_speculation_validator.sv
// Validates clear-queue entries: counts retires for good predictions, rewinds the FIFO tail on mispredicts.
// Latency: entry accepted in IDLE, earliest ACK the following cycle; ValidatedPulse one cycle after a COUNT ACK.
// Backpressure: holds the entry until the depth retires or RewindACK; clk_en low freezes all state. Error flag: RUNAHEAD_VALIDATOR_ERROR_EN.
module runahead_speculation_validator #(
    parameter int COUNTERBITWIDTH = 6
) (
    input  logic clk,
    input  logic async_rst,
    input  logic clk_en,
    runahead_speculation_validator_if.slave vif
);
    localparam int W = COUNTERBITWIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REWIND = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   target_q, target_d;
    logic [W-1:0]   retired_count_q, retired_count_d;
    logic           validated_pulse_q, validated_pulse_d;

    logic [W:0]     sum;
    logic [W:0]     surplus;
    logic [W-1:0]   sum_sat;
    logic [W-1:0]   surplus_sat;
    logic           count_done;
    logic           ack;

    // One bit wider so a retire at full count shows up as sum[W] instead of wrapping.
    always_comb begin
        sum         = {1'b0, retired_count_q} + {{W{1'b0}}, vif.SpeculativeRetire};
        surplus     = sum - {1'b0, target_q};
        sum_sat     = sum[W]     ? {W{1'b1}} : sum[W-1:0];
        surplus_sat = surplus[W] ? {W{1'b1}} : surplus[W-1:0];
        count_done  = (sum >= {1'b0, target_q});
    end

    always_comb begin
        state_d           = state_q;
        target_d          = target_q;
        retired_count_d   = retired_count_q;
        validated_pulse_d = 1'b0;
        ack               = 1'b0;
        case (state_q)
            IDLE: begin
                retired_count_d = sum_sat;
                if (vif.ClearEntryValid) begin
                    target_d = vif.ClearEntryDepth;
                    state_d  = vif.ClearEntryMispredicted ? REWIND : COUNT;
                end
            end
            COUNT: begin
                if (count_done) begin
                    ack               = clk_en;
                    retired_count_d   = surplus_sat;
                    validated_pulse_d = 1'b1;
                    state_d           = IDLE;
                end else begin
                    retired_count_d = sum_sat;
                end
            end
            REWIND: begin
                // Retires seen here belong to squashed work and are dropped.
                if (vif.RewindACK) begin
                    ack             = clk_en;
                    retired_count_d = '0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q           <= IDLE;
            target_q          <= '0;
            retired_count_q   <= '0;
            validated_pulse_q <= 1'b0;
        end else if (clk_en) begin
            state_q           <= state_d;
            target_q          <= target_d;
            retired_count_q   <= retired_count_d;
            validated_pulse_q <= validated_pulse_d;
        end
    end

`ifdef RUNAHEAD_VALIDATOR_ERROR_EN
    logic protocol_error_q, protocol_error_d;

    always_comb begin
        protocol_error_d = protocol_error_q;
        case (state_q)
            IDLE:    if (sum[W]) protocol_error_d = 1'b1;
            COUNT:   if (count_done ? surplus[W] : sum[W]) protocol_error_d = 1'b1;
            REWIND:  if (vif.SpeculativeRetire) protocol_error_d = 1'b1;
            default: protocol_error_d = protocol_error_q;
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            protocol_error_q <= 1'b0;
        end else if (clk_en) begin
            protocol_error_q <= protocol_error_d;
        end
    end

    assign vif.ProtocolError = protocol_error_q;
`else
    assign vif.ProtocolError = 1'b0;
`endif

    assign vif.ClearEntryACK  = ack;
    assign vif.RewindValid    = (state_q == REWIND);
    assign vif.RewindDepth    = (state_q == REWIND) ? target_q : '0;
    assign vif.ValidatedPulse = validated_pulse_q;
    assign vif.ValidatorBusy  = (state_q != IDLE);
endmodule

// File: tb/tb_runahead_speculation_validator.sv
// Directed bench for runahead_speculation_validator: main instance at width 6, a width-3 instance for saturation.
module tb_runahead_speculation_validator;
    logic clk = 1'b0;
    logic async_rst;
    logic clk_en;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef RUNAHEAD_VALIDATOR_ERROR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    runahead_speculation_validator_if #(.COUNTERBITWIDTH(6)) vif_a ();
    runahead_speculation_validator_if #(.COUNTERBITWIDTH(3)) vif_b ();

    runahead_speculation_validator #(.COUNTERBITWIDTH(6)) dut_a (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .vif(vif_a.slave)
    );
    runahead_speculation_validator #(.COUNTERBITWIDTH(3)) dut_b (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .vif(vif_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [5:0] d, input logic r, input logic ra);
        vif_a.ClearEntryValid        = v;
        vif_a.ClearEntryMispredicted = m;
        vif_a.ClearEntryDepth        = d;
        vif_a.SpeculativeRetire      = r;
        vif_a.RewindACK              = ra;
    endtask

    initial begin
        async_rst = 1'b1;
        clk_en    = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        vif_b.ClearEntryValid        = 1'b0;
        vif_b.ClearEntryMispredicted = 1'b0;
        vif_b.ClearEntryDepth        = 3'd0;
        vif_b.SpeculativeRetire      = 1'b0;
        vif_b.RewindACK              = 1'b0;

        // Reset state
        #12;
        check("rst_ack",   vif_a.ClearEntryACK,  0);
        check("rst_rwv",   vif_a.RewindValid,    0);
        check("rst_busy",  vif_a.ValidatorBusy,  0);
        check("rst_pulse", vif_a.ValidatedPulse, 0);
        check("rst_err",   vif_a.ProtocolError,  0);
        async_rst = 1'b0;
        tick();

        // Entry {0,3}, three retires
        drive(1'b1, 1'b0, 6'd3, 1'b0, 1'b0);
        #3 check("t1_idle_ack", vif_a.ClearEntryACK, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 6'd3, 1'b1, 1'b0);
            #3;
            check("t1_busy", vif_a.ValidatorBusy, 1);
            check("t1_ack",  vif_a.ClearEntryACK, (i == 2) ? 1 : 0);
            tick();
        end
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        #3;
        check("t1_pulse", vif_a.ValidatedPulse, 1);
        check("t1_busy_after", vif_a.ValidatorBusy, 0);
        check("t1_count", dut_a.retired_count_q, 0);
        tick();
        check("t1_pulse_one_cycle", vif_a.ValidatedPulse, 0);

        // Five banked retires, then entry {0,2}
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
            tick();
        end
        check("t2_banked", dut_a.retired_count_q, 5);
        drive(1'b1, 1'b0, 6'd2, 1'b0, 1'b0);
        tick();
        #3 check("t2_ack_first", vif_a.ClearEntryACK, 1);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        #3;
        check("t2_surplus", dut_a.retired_count_q, 3);
        check("t2_pulse", vif_a.ValidatedPulse, 1);

        // Mispredict {1,5}, rewind held off three cycles
        tick();
        drive(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #3;
            check("t3_rwv",   vif_a.RewindValid,   1);
            check("t3_depth", vif_a.RewindDepth,   5);
            check("t3_noack", vif_a.ClearEntryACK, 0);
            tick();
        end
        drive(1'b1, 1'b1, 6'd5, 1'b0, 1'b1);
        #3 check("t3_ack", vif_a.ClearEntryACK, 1);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        #3;
        check("t3_idle",  vif_a.ValidatorBusy, 0);
        check("t3_rwv_off", vif_a.RewindValid, 0);
        check("t3_count", dut_a.retired_count_q, 0);
        check("t3_nopulse", vif_a.ValidatedPulse, 0);

        // Zero-depth entry
        tick();
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        #3 check("t4_ack", vif_a.ClearEntryACK, 1);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        #3 check("t4_pulse", vif_a.ValidatedPulse, 1);

        // Zero-depth entry with clk_en low during COUNT
        tick();
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        clk_en = 1'b0;
        #3 check("t4_gate_ack", vif_a.ClearEntryACK, 0);
        tick();
        #3;
        check("t4_gate_busy",  vif_a.ValidatorBusy,  1);
        check("t4_gate_ack2",  vif_a.ClearEntryACK,  0);
        check("t4_gate_pulse", vif_a.ValidatedPulse, 0);
        clk_en = 1'b1;
        #1 check("t4_ungate_ack", vif_a.ClearEntryACK, 1);
        tick();
        #3;
        check("t4_ungate_pulse", vif_a.ValidatedPulse, 1);
        check("t4_ungate_idle",  vif_a.ValidatorBusy,  0);

        // Async reset mid-REWIND
        tick();
        drive(1'b1, 1'b1, 6'd4, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        #1 check("t5_pre_ack", vif_a.ClearEntryACK, 1);
        async_rst = 1'b1;
        #1;
        check("t5_rwv",  vif_a.RewindValid,   0);
        check("t5_busy", vif_a.ValidatorBusy, 0);
        check("t5_ack",  vif_a.ClearEntryACK, 0);
        #1 async_rst = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        #3 check("t5_idle_after", vif_a.ValidatorBusy, 0);

        // Retire during REWIND, flag must stay sticky
        tick();
        drive(1'b1, 1'b1, 6'd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        #3 check("t6_err", vif_a.ProtocolError, ERR_EXP);
        tick();
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tick();
        #3 check("t6_err_sticky", vif_a.ProtocolError, ERR_EXP);
        async_rst = 1'b1;
        #1 check("t6_err_rst", vif_a.ProtocolError, 0);
        #1 async_rst = 1'b0;

        // Width-3 saturation: eight banked retires
        tick();
        vif_b.SpeculativeRetire = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        vif_b.SpeculativeRetire = 1'b0;
        #3;
        check("t7_sat",     dut_b.retired_count_q, 7);
        check("t7_err",     vif_b.ProtocolError,   ERR_EXP);
        check("t7_a_clean", vif_a.ProtocolError,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
